// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and
// legal-range checks used by the receiver and transmitter.
`timescale 1ns/1ps
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic bit bits_data_ok(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit oversample_ok(input int os);
    return (os >= 4) && ((os % 2) == 0);
  endfunction

  function automatic bit parity_mode_ok(input int pm);
    return (pm >= PARITY_NONE) && (pm <= PARITY_ODD);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen per use so an idle line does not look active after reset.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two register stages to settle metastability before the value is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits LSB first, optional even/odd
// parity, stop length in ticks; reports parity, framing and break errors.
`timescale 1ns/1ps
module uart_rx_cfg
  import uart_defs::*;
#(
  parameter int BITS_DATA   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SB_TICK     = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic                 rx_done_tick,
  output logic [BITS_DATA-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int TW = max2(1, $clog2(max2(OVERSAMPLE, SB_TICK)));
  localparam int BW = max2(1, $clog2(BITS_DATA));

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_DATA - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam bit ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  // Refuse to elaborate with a frame format the datapath cannot handle.
  if (!bits_data_ok(BITS_DATA)) begin : g_bad_bits
    $error("uart_rx_cfg: BITS_DATA must be in 5..9");
  end
  if (!oversample_ok(OVERSAMPLE)) begin : g_bad_os
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 4");
  end
  if (!parity_mode_ok(PARITY_MODE)) begin : g_bad_pm
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end

  logic                 rx_s;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [BITS_DATA-1:0] shift_reg;
  logic                 par_bit;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (i_clk),
    .rst (i_reset),
    .d   (rx),
    .q   (rx_s)
  );

  // Frame FSM: hunt for start, sample each bit at its centre, judge the frame
  // on the stop sample and publish the word plus error flags with a strobe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      data_out     <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Start detection does not wait for a tick so the half-bit
          // countdown begins as early as possible.
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (tick_cnt == T_HALF) begin
              if (!rx_s) begin
                state    <= ST_DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= ST_IDLE;  // short low pulse: not a real start bit
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (tick_cnt == T_BIT) begin
              shift_reg <= {rx_s, shift_reg[BITS_DATA-1:1]};
              tick_cnt  <= '0;
              if (bit_cnt == B_LAST) begin
                state <= HAS_PARITY ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (s_tick) begin
            if (tick_cnt == T_BIT) begin
              par_bit  <= rx_s;
              tick_cnt <= '0;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (tick_cnt == T_STOP) begin
              state        <= ST_IDLE;
              tick_cnt     <= '0;
              data_out     <= shift_reg;
              frame_err    <= ~rx_s;
              parity_err   <= HAS_PARITY && ((^shift_reg ^ par_bit) != ODD_PARITY);
              break_det    <= ~(|shift_reg) & ~(HAS_PARITY & par_bit) & ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2 with continuous
// ticks) fed by a bit-level line driver and checked against a frame model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int OS = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } res_t;

  typedef struct {
    int   inst;
    int   cyc;
    res_t r;
  } frame_t;

  // Per-instance configuration: A = 8N1 (1-in-3 ticks), B = 7E1, C = 8N2 (ticks always on)
  int nbits [3] = '{8, 7, 8};
  int pm    [3] = '{0, 1, 0};
  int sb    [3] = '{16, 16, 32};
  int div   [3] = '{3, 3, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rx_v = 3'b111;
  logic [2:0] tick_v = 3'b000;
  int   tcnt [3] = '{0, 0, 0};
  int   cyc = 0;

  logic       done_a, perr_a, ferr_a, brk_a;
  logic [7:0] data_a;
  logic       done_b, perr_b, ferr_b, brk_b;
  logic [6:0] data_b;
  logic       done_c, perr_c, ferr_c, brk_c;
  logic [7:0] data_c;

  int errors = 0;
  int checks = 0;
  int cons_err = 0;
  int start_cyc [3] = '{0, 0, 0};
  logic [2:0] prev_done = 3'b000;
  frame_t mon_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.BITS_DATA(8), .OVERSAMPLE(OS), .SB_TICK(16), .PARITY_MODE(0)) u_a (
    .i_clk(clk), .i_reset(rst), .rx(rx_v[0]), .s_tick(tick_v[0]),
    .rx_done_tick(done_a), .data_out(data_a), .parity_err(perr_a),
    .frame_err(ferr_a), .break_det(brk_a));

  uart_rx_cfg #(.BITS_DATA(7), .OVERSAMPLE(OS), .SB_TICK(16), .PARITY_MODE(1)) u_b (
    .i_clk(clk), .i_reset(rst), .rx(rx_v[1]), .s_tick(tick_v[1]),
    .rx_done_tick(done_b), .data_out(data_b), .parity_err(perr_b),
    .frame_err(ferr_b), .break_det(brk_b));

  uart_rx_cfg #(.BITS_DATA(8), .OVERSAMPLE(OS), .SB_TICK(32), .PARITY_MODE(0)) u_c (
    .i_clk(clk), .i_reset(rst), .rx(rx_v[2]), .s_tick(tick_v[2]),
    .rx_done_tick(done_c), .data_out(data_c), .parity_err(perr_c),
    .frame_err(ferr_c), .break_det(brk_c));

  // Tick generators change on the falling edge so the DUT sees stable enables.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tcnt[i] >= div[i] - 1) begin
        tcnt[i]   <= 0;
        tick_v[i] <= 1'b1;
      end else begin
        tcnt[i]   <= tcnt[i] + 1;
        tick_v[i] <= 1'b0;
      end
    end
  end

  function automatic frame_t grab(input int i);
    frame_t f;
    f.inst = i;
    f.cyc  = cyc;
    case (i)
      0:       f.r = {1'b0, data_a, perr_a, ferr_a, brk_a};
      1:       f.r = {2'b00, data_b, perr_b, ferr_b, brk_b};
      default: f.r = {1'b0, data_c, perr_c, ferr_c, brk_c};
    endcase
    return f;
  endfunction

  // Strobe monitor: queue every completed frame, count back-to-back strobes.
  always @(negedge clk) begin
    prev_done <= {done_c, done_b, done_a};
    if (({done_c, done_b, done_a} & prev_done) != 3'b000) cons_err <= cons_err + 1;
    if (done_a) mon_q.push_back(grab(0));
    if (done_b) mon_q.push_back(grab(1));
    if (done_c) mon_q.push_back(grab(2));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic par_line(input int i, input logic [8:0] d, input bit flip);
    logic p = 1'b0;
    for (int b = 0; b < nbits[i]; b++) p ^= d[b];
    if (pm[i] == 2) p = ~p;
    return p ^ flip;
  endfunction

  function automatic res_t model(input int i, input logic [8:0] d, input bit flip, input bit stop_ok);
    res_t r;
    logic [8:0] m = '0;
    for (int b = 0; b < nbits[i]; b++) m[b] = d[b];
    r.data = m;
    r.pe   = (pm[i] != 0) && flip;
    r.fe   = !stop_ok;
    r.bd   = (m == 9'd0) && (pm[i] == 0 || par_line(i, d, flip) == 1'b0) && !stop_ok;
    return r;
  endfunction

  function automatic string fstr(input res_t r);
    return $sformatf("data=%03h pe=%b fe=%b bd=%b", r.data, r.pe, r.fe, r.bd);
  endfunction

  // ---------------- line driver ----------------
  task automatic wait_ticks(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (tick_v[i] !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int i, input logic val, input int n);
    rx_v[i] = val;
    wait_ticks(i, n);
  endtask

  // A bad stop bit is held low only long enough to be sampled, so the
  // receiver's re-armed start search sees the line back high and rejects it.
  task automatic send_frame(input int i, input logic [8:0] d, input bit flip, input bit stop_ok);
    start_cyc[i] = cyc;
    drive(i, 1'b0, OS);
    for (int b = 0; b < nbits[i]; b++) drive(i, d[b], OS);
    if (pm[i] != 0) drive(i, par_line(i, d, flip), OS);
    if (stop_ok) begin
      drive(i, 1'b1, sb[i]);
    end else begin
      drive(i, 1'b0, sb[i] - OS / 2 + 4);
      drive(i, 1'b1, OS / 2);
    end
  endtask

  task automatic wait_strobe(input int i, output frame_t f, output bit ok);
    ok = 1'b0;
    f.inst = -1; f.cyc = 0; f.r = '0;
    for (int k = 0; k < 400 && mon_q.size() == 0; k++) @(negedge clk);
    if (mon_q.size() > 0) begin
      f  = mon_q.pop_front();
      ok = (f.inst == i);
      $display("frame inst=%0d cyc=%0d %s", f.inst, f.cyc, fstr(f.r));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({done_a, data_a, perr_a, ferr_a, brk_a} !== 12'd0) begin
      errors++; $display("FAIL reset_a: got %03h want 000", {done_a, data_a, perr_a, ferr_a, brk_a});
    end
    checks++;
    if ({done_b, data_b, perr_b, ferr_b, brk_b} !== 11'd0) begin
      errors++; $display("FAIL reset_b: got %03h want 000", {done_b, data_b, perr_b, ferr_b, brk_b});
    end
    checks++;
    if ({done_c, data_c, perr_c, ferr_c, brk_c} !== 12'd0) begin
      errors++; $display("FAIL reset_c: got %03h want 000", {done_c, data_c, perr_c, ferr_c, brk_c});
    end
    rst = 1'b0;
    wait_ticks(0, 4);
  endtask

  task automatic test_basic;
    frame_t f; bit ok; res_t e;
    send_frame(0, 9'h055, 1'b0, 1'b1);
    e = model(0, 9'h055, 1'b0, 1'b1);
    wait_strobe(0, f, ok);
    checks++;
    if (!ok || f.r !== e) begin
      errors++; $display("FAIL basic_55: got %s (ok=%0d) want %s", fstr(f.r), ok, fstr(e));
    end
    drive(0, 1'b1, 2 * OS);
    checks++;
    if (mon_q.size() != 0) begin
      errors++; $display("FAIL basic_single_strobe: got %0d extra strobes want 0", mon_q.size());
      mon_q.delete();
    end
  endtask

  task automatic test_parity;
    frame_t f; bit ok; res_t e;
    for (int flip = 0; flip < 2; flip++) begin
      send_frame(1, 9'h041, flip[0], 1'b1);
      e = model(1, 9'h041, flip[0], 1'b1);
      wait_strobe(1, f, ok);
      checks++;
      if (!ok || f.r !== e) begin
        errors++; $display("FAIL parity_41_flip%0d: got %s (ok=%0d) want %s", flip, fstr(f.r), ok, fstr(e));
      end
    end
    drive(1, 1'b1, OS);
    checks++;
    if ({data_b, perr_b} !== {7'h41, 1'b1}) begin
      errors++; $display("FAIL parity_hold: got data=%02h pe=%b want data=41 pe=1", data_b, perr_b);
    end
  endtask

  task automatic test_frame_err;
    frame_t f; bit ok; res_t e;
    send_frame(0, 9'h0A3, 1'b0, 1'b0);
    e = model(0, 9'h0A3, 1'b0, 1'b0);
    wait_strobe(0, f, ok);
    checks++;
    if (!ok || f.r !== e) begin
      errors++; $display("FAIL frame_err_a3: got %s (ok=%0d) want %s", fstr(f.r), ok, fstr(e));
    end
    drive(0, 1'b1, 2 * OS);
    checks++;
    if (mon_q.size() != 0) begin
      errors++; $display("FAIL frame_err_rearm: got %0d extra strobes want 0", mon_q.size());
      mon_q.delete();
    end
  endtask

  // Line low for two zero frames (start+8 data+low stop, then immediate
  // restart); it is released while the third restart is still in its
  // half-bit start check, so exactly two break frames are expected.
  task automatic test_break;
    frame_t f; bit ok; res_t e;
    drive(0, 1'b0, 19 * OS + 4);
    drive(0, 1'b1, 3 * OS);
    e = model(0, 9'h000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_strobe(0, f, ok);
      checks++;
      if (!ok || f.r !== e) begin
        errors++; $display("FAIL break_%0d: got %s (ok=%0d) want %s", k, fstr(f.r), ok, fstr(e));
      end
    end
    checks++;
    if (mon_q.size() != 0) begin
      errors++; $display("FAIL break_count: got %0d extra strobes want 0", mon_q.size());
      mon_q.delete();
    end
    send_frame(0, 9'h00F, 1'b0, 1'b1);
    e = model(0, 9'h00F, 1'b0, 1'b1);
    wait_strobe(0, f, ok);
    checks++;
    if (!ok || f.r !== e) begin
      errors++; $display("FAIL break_clear_0f: got %s (ok=%0d) want %s", fstr(f.r), ok, fstr(e));
    end
  endtask

  task automatic test_glitch;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 2 * OS);
    checks++;
    if (mon_q.size() != 0) begin
      errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", mon_q.size());
      mon_q.delete();
    end
    checks++;
    if ({data_a, perr_a, ferr_a, brk_a} !== {8'h0F, 3'b000}) begin
      errors++; $display("FAIL glitch_hold: got data=%02h flags=%b%b%b want data=0f flags=000",
                         data_a, perr_a, ferr_a, brk_a);
    end
  endtask

  task automatic test_reset_mid;
    frame_t f; bit ok; res_t e;
    logic [8:0] d = 9'h05A;
    drive(0, 1'b0, OS);
    for (int b = 0; b < 3; b++) drive(0, d[b], OS);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({done_a, data_a, perr_a, ferr_a, brk_a} !== 12'd0) begin
      errors++; $display("FAIL reset_mid_async: got %03h want 000", {done_a, data_a, perr_a, ferr_a, brk_a});
    end
    rx_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done_a, data_a, perr_a, ferr_a, brk_a} !== 12'd0) begin
      errors++; $display("FAIL reset_mid_held: got %03h want 000", {done_a, data_a, perr_a, ferr_a, brk_a});
    end
    rst = 1'b0;
    drive(0, 1'b1, 12 * OS);
    checks++;
    if (mon_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_abort: got %0d strobes want 0", mon_q.size());
      mon_q.delete();
    end
    send_frame(0, 9'h03C, 1'b0, 1'b1);
    e = model(0, 9'h03C, 1'b0, 1'b1);
    wait_strobe(0, f, ok);
    checks++;
    if (!ok || f.r !== e) begin
      errors++; $display("FAIL reset_mid_3c: got %s (ok=%0d) want %s", fstr(f.r), ok, fstr(e));
    end
  endtask

  // Continuous ticks, 2 stop bits: latency from the line fall is the tick
  // count of the frame plus 2..3 clocks of synchroniser/start detection.
  task automatic test_back_to_back;
    frame_t f; bit ok; res_t e;
    logic [8:0] words [2] = '{9'h0FF, 9'h000};
    int starts [2];
    int t_frame = OS / 2 + nbits[2] * OS + sb[2];
    int lat;
    for (int k = 0; k < 2; k++) begin
      send_frame(2, words[k], 1'b0, 1'b1);
      starts[k] = start_cyc[2];
    end
    for (int k = 0; k < 2; k++) begin
      e = model(2, words[k], 1'b0, 1'b1);
      wait_strobe(2, f, ok);
      checks++;
      if (!ok || f.r !== e) begin
        errors++; $display("FAIL b2b_word%0d: got %s (ok=%0d) want %s", k, fstr(f.r), ok, fstr(e));
      end
      lat = f.cyc - starts[k];
      checks++;
      if (lat < t_frame + 2 || lat > t_frame + 3) begin
        errors++; $display("FAIL b2b_latency%0d: got %0d clocks want %0d..%0d", k, lat, t_frame + 2, t_frame + 3);
      end
    end
  endtask

  task automatic test_random;
    frame_t f; bit ok; res_t e;
    for (int k = 0; k < 8; k++) begin
      int         i       = k % 2;
      logic [8:0] d       = 9'($urandom_range(0, 511));
      bit         flip    = (pm[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bit         stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(i, d, flip, stop_ok);
      e = model(i, d, flip, stop_ok);
      wait_strobe(i, f, ok);
      checks++;
      if (!ok || f.r !== e) begin
        errors++; $display("FAIL random_%0d inst%0d: got %s (ok=%0d) want %s", k, i, fstr(f.r), ok, fstr(e));
      end
      drive(i, 1'b1, OS);
    end
  endtask

  task automatic test_strobe_width;
    checks++;
    if (cons_err != 0) begin
      errors++; $display("FAIL strobe_width: got %0d consecutive-cycle strobes want 0", cons_err);
    end
    checks++;
    if (mon_q.size() != 0) begin
      errors++; $display("FAIL stray_strobes: got %0d unclaimed strobes want 0", mon_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_strobe_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
